// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the instruction/data memory
// arbiter. Provides the FSM state encoding, the owner encoding, bus widths, the
// halt-vector bit index driven by bus_err, and the watchdog width helper.
package mem_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

    // Bit of the core's HALTTYPE vector that bus_err drives.
    localparam int HALT_BUS = 3;

    // Watchdog counter width; a disabled watchdog still gets a 1-bit counter
    // so that no zero-width vector is ever declared.
    function automatic int timer_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one word-addressed req/ack memory bus.
//   req/rw/addr/wdata : request side (driven by the master)
//   rdata/ack         : response side (driven by the slave)
// modport master: issues requests (arbiter -> memory).
// modport slave : serves requests (core ports -> arbiter).
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic              req;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (
        output req, rw, addr, wdata,
        input  rdata, ack
    );

    modport slave (
        input  req, rw, addr, wdata,
        output rdata, ack
    );

endinterface

// File: rtl/mem_arbiter_timer.sv
// mem_arb_timer: watchdog counter for one memory transaction.
//   clk, reset_n : clock, synchronous active-low reset
//   clear        : restart the count from zero (grant edge)
//   run          : count one cycle of an outstanding request
//   expired      : the transaction has waited TIMEOUT-1 counted cycles; the
//                  abort takes effect on the next edge unless m_ack arrives
// TIMEOUT = 0 disables the watchdog (expired never rises).
module mem_arb_timer
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int           W     = timer_width(TIMEOUT);
    localparam int           LIMIT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [W-1:0] SAT   = '1;

    logic [W-1:0] count;

    // Saturating count so a long stall can never wrap back below the limit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run && (count != SAT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (TIMEOUT != 0) && (count == LIMIT[W-1:0]);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between the instruction-fetch
// port and the data port, one transaction at a time.
//   clk, reset_n : clock, synchronous active-low reset
//   ibus (slave) : fetch port; rw/wdata are ignored, fetches are always reads
//   dbus (slave) : data port; rw = 1 write, 0 read
//   mbus (master): registered memory request, m_ack/m_rdata response
//   owner        : 0 = fetch, 1 = data; meaningful while busy
//   bus_err      : sticky watchdog-abort flag, cleared only by reset; feeds
//                  bit HALT_BUS of the core halt vector
// DATA_FIRST = 1: data wins ties; 0: round-robin (last winner loses a tie).
// TIMEOUT cycles of m_req without m_ack abort the transaction (0 = never).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter bit DATA_FIRST = 1'b1,
    parameter int TIMEOUT    = 15
) (
    input  logic          clk,
    input  logic          reset_n,
    mem_arbiter_if.slave  ibus,
    mem_arbiter_if.slave  dbus,
    mem_arbiter_if.master mbus,
    output logic          owner,
    output logic          bus_err
);

    arb_state_t state, state_nxt;
    owner_t     owner_q, owner_nxt;
    owner_t     last_grant, last_grant_nxt;
    owner_t     grant_owner;

    logic i_elig, d_elig;
    logic grant_valid;
    logic done, abort;
    logic timer_expired;

    logic              m_req_nxt, m_rw_nxt;
    logic [ADDR_W-1:0] m_addr_nxt;
    logic [DATA_W-1:0] m_wdata_nxt;
    logic              i_ack_nxt, d_ack_nxt;
    logic [DATA_W-1:0] i_rdata_nxt, d_rdata_nxt;
    logic              bus_err_nxt;

    // Fetches are reads by definition, so these request fields carry nothing.
    logic unused_fetch_fields;
    assign unused_fetch_fields = ^{ibus.rw, ibus.wdata};

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (grant_valid),
        .run     (state == ARB_BUSY),
        .expired (timer_expired)
    );

    // State register together with every registered output of the block.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ARB_IDLE;
            owner_q    <= OWNER_I;
            last_grant <= OWNER_I;
            mbus.req   <= 1'b0;
            mbus.rw    <= 1'b0;
            mbus.addr  <= '0;
            mbus.wdata <= '0;
            ibus.ack   <= 1'b0;
            dbus.ack   <= 1'b0;
            ibus.rdata <= '0;
            dbus.rdata <= '0;
            bus_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner_q    <= owner_nxt;
            last_grant <= last_grant_nxt;
            mbus.req   <= m_req_nxt;
            mbus.rw    <= m_rw_nxt;
            mbus.addr  <= m_addr_nxt;
            mbus.wdata <= m_wdata_nxt;
            ibus.ack   <= i_ack_nxt;
            dbus.ack   <= d_ack_nxt;
            ibus.rdata <= i_rdata_nxt;
            dbus.rdata <= d_rdata_nxt;
            bus_err    <= bus_err_nxt;
        end
    end

    // A port whose ack is still high is mid-handshake and may be dropping req
    // right now, so it is not eligible for a fresh grant this cycle.
    always_comb begin
        i_elig      = ibus.req && !ibus.ack;
        d_elig      = dbus.req && !dbus.ack;
        grant_valid = 1'b0;
        grant_owner = OWNER_I;
        done        = 1'b0;
        abort       = 1'b0;
        state_nxt   = state;
        case (state)
            ARB_IDLE: begin
                grant_valid = i_elig || d_elig;
                if (d_elig && (!i_elig || DATA_FIRST || (last_grant == OWNER_I))) begin
                    grant_owner = OWNER_D;
                end
                if (grant_valid) begin
                    state_nxt = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                // m_ack on the expiry edge is a normal completion.
                done  = mbus.ack;
                abort = !mbus.ack && timer_expired;
                if (done || abort) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // Next values of the registered outputs; everything holds unless a grant
    // or a completion changes it, and the ack pulses default low.
    always_comb begin
        m_req_nxt      = mbus.req;
        m_rw_nxt       = mbus.rw;
        m_addr_nxt     = mbus.addr;
        m_wdata_nxt    = mbus.wdata;
        i_ack_nxt      = 1'b0;
        d_ack_nxt      = 1'b0;
        i_rdata_nxt    = ibus.rdata;
        d_rdata_nxt    = dbus.rdata;
        bus_err_nxt    = bus_err;
        owner_nxt      = owner_q;
        last_grant_nxt = last_grant;

        if (grant_valid) begin
            owner_nxt      = grant_owner;
            last_grant_nxt = grant_owner;
            m_req_nxt      = 1'b1;
            if (grant_owner == OWNER_D) begin
                m_rw_nxt    = dbus.rw;
                m_addr_nxt  = dbus.addr;
                m_wdata_nxt = dbus.wdata;
            end else begin
                m_rw_nxt    = 1'b0;
                m_addr_nxt  = ibus.addr;
                m_wdata_nxt = '0;
            end
        end

        if (done || abort) begin
            m_req_nxt = 1'b0;
            if (owner_q == OWNER_D) begin
                d_ack_nxt = 1'b1;
            end else begin
                i_ack_nxt = 1'b1;
            end
            if (abort) begin
                bus_err_nxt = 1'b1;
                if (owner_q == OWNER_D) begin
                    d_rdata_nxt = '0;
                end else begin
                    i_rdata_nxt = '0;
                end
            end else if (!mbus.rw) begin
                if (owner_q == OWNER_D) begin
                    d_rdata_nxt = mbus.rdata;
                end else begin
                    i_rdata_nxt = mbus.rdata;
                end
            end
        end
    end

    assign owner = owner_q;

endmodule
